// File: rtl/sdram_rw_arbiter.sv
// sdram_rw_arbiter
// Shares one SDRAM controller port between the write-FIFO drain (burst write)
// and the read-FIFO fill (burst read). Writes normally win, but after
// MAX_WR_RUN back-to-back write bursts a pending read gets the next slot.
// A request that is not acknowledged within ACK_TIMEOUT cycles is withdrawn
// and flagged. All outputs are registered and reflect the state being entered.
module sdram_rw_arbiter #(
  parameter int MAX_WR_RUN  = 4,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic       clk_ref,
  input  logic       rst_n,
  input  logic       sdram_init_done,
  input  logic [9:0] wrf_use,
  input  logic [9:0] wr_length,
  input  logic [9:0] rdf_use,
  input  logic [9:0] rd_length,
  input  logic       read_valid,
  input  logic       sdram_wr_ack,
  input  logic       sdram_rd_ack,
  output logic       sdram_wr_req,
  output logic       sdram_rd_req,
  output logic       wr_burst_done,
  output logic       rd_burst_done,
  output logic       timeout_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_REQ   = 3'd1,
    WR_BURST = 3'd2,
    RD_REQ   = 3'd3,
    RD_BURST = 3'd4
  } state_t;

  // Last counter value allowed in a REQ state; reaching it withdraws the request.
  localparam logic [9:0] TMO_LAST = 10'(ACK_TIMEOUT - 1);
  localparam logic [3:0] RUN_MAX  = 4'(MAX_WR_RUN);
  localparam logic [3:0] RUN_SAT  = 4'd15;

  state_t     state;
  state_t     state_nxt;
  logic [9:0] tmo_cnt;
  logic [3:0] wr_run;
  logic       wr_elig;
  logic       rd_elig;
  logic       tmo_hit;
  logic       wr_done_nxt;
  logic       rd_done_nxt;
  logic       tmo_nxt;

  // A write is worth starting only when a full burst is already buffered;
  // a read only when the read FIFO has room for a full burst.
  assign wr_elig = sdram_init_done && (wr_length != 10'd0) && (wrf_use >= wr_length);
  assign rd_elig = sdram_init_done && read_valid && (rd_length != 10'd0) &&
                   (rdf_use < rd_length);
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // Next-state decision; ack beats withdrawal, withdrawal beats timeout.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (wr_elig && (!rd_elig || (wr_run < RUN_MAX)))
          state_nxt = WR_REQ;
        else if (rd_elig)
          state_nxt = RD_REQ;
        else
          state_nxt = IDLE;
      end
      WR_REQ: begin
        if (sdram_wr_ack)
          state_nxt = WR_BURST;
        else if (!wr_elig || tmo_hit)
          state_nxt = IDLE;
        else
          state_nxt = WR_REQ;
      end
      WR_BURST: begin
        // A burst in flight always runs to completion, even if init drops.
        if (!sdram_wr_ack)
          state_nxt = IDLE;
        else
          state_nxt = WR_BURST;
      end
      RD_REQ: begin
        if (sdram_rd_ack)
          state_nxt = RD_BURST;
        else if (!rd_elig || tmo_hit)
          state_nxt = IDLE;
        else
          state_nxt = RD_REQ;
      end
      RD_BURST: begin
        if (!sdram_rd_ack)
          state_nxt = IDLE;
        else
          state_nxt = RD_BURST;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Event pulses derived from the transition being taken this cycle.
  always_comb begin
    wr_done_nxt = (state == WR_BURST) && (state_nxt == IDLE);
    rd_done_nxt = (state == RD_BURST) && (state_nxt == IDLE);
    tmo_nxt     = ((state == WR_REQ) && !sdram_wr_ack && wr_elig && tmo_hit) ||
                  ((state == RD_REQ) && !sdram_rd_ack && rd_elig && tmo_hit);
  end

  // State, timeout counter, write-run counter and registered outputs.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tmo_cnt       <= 10'd0;
      wr_run        <= 4'd0;
      sdram_wr_req  <= 1'b0;
      sdram_rd_req  <= 1'b0;
      wr_burst_done <= 1'b0;
      rd_burst_done <= 1'b0;
      timeout_err   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state <= state_nxt;

      // Counts cycles spent waiting for an ack; any state change restarts it.
      if ((state_nxt != state) || ((state != WR_REQ) && (state != RD_REQ)))
        tmo_cnt <= 10'd0;
      else
        tmo_cnt <= tmo_cnt + 10'd1;

      // Consecutive write bursts; reset by a completed read or by an idle
      // cycle with no read waiting, so starvation control only bites when
      // reads are actually pending.
      if (wr_done_nxt) begin
        if (wr_run != RUN_SAT)
          wr_run <= wr_run + 4'd1;
      end else if (rd_done_nxt) begin
        wr_run <= 4'd0;
      end else if ((state == IDLE) && (state_nxt == IDLE) && !rd_elig) begin
        wr_run <= 4'd0;
      end

      sdram_wr_req  <= (state_nxt == WR_REQ);
      sdram_rd_req  <= (state_nxt == RD_REQ);
      wr_burst_done <= wr_done_nxt;
      rd_burst_done <= rd_done_nxt;
      timeout_err   <= tmo_nxt;
      busy          <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// Bench for sdram_rw_arbiter: per-cycle vector table, then hand sequences
// for long bursts, write-run fairness, ack timeout and asynchronous reset.
module tb_sdram_rw_arbiter;

  logic       clk_ref = 1'b0;
  logic       rst_n;
  logic       sdram_init_done;
  logic [9:0] wrf_use;
  logic [9:0] wr_length;
  logic [9:0] rdf_use;
  logic [9:0] rd_length;
  logic       read_valid;
  logic       sdram_wr_ack;
  logic       sdram_rd_ack;
  logic       sdram_wr_req;
  logic       sdram_rd_req;
  logic       wr_burst_done;
  logic       rd_burst_done;
  logic       timeout_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk_ref = ~clk_ref;

  sdram_rw_arbiter #(.MAX_WR_RUN(4), .ACK_TIMEOUT(1023)) dut (
    .clk_ref         (clk_ref),
    .rst_n           (rst_n),
    .sdram_init_done (sdram_init_done),
    .wrf_use         (wrf_use),
    .wr_length       (wr_length),
    .rdf_use         (rdf_use),
    .rd_length       (rd_length),
    .read_valid      (read_valid),
    .sdram_wr_ack    (sdram_wr_ack),
    .sdram_rd_ack    (sdram_rd_ack),
    .sdram_wr_req    (sdram_wr_req),
    .sdram_rd_req    (sdram_rd_req),
    .wr_burst_done   (wr_burst_done),
    .rd_burst_done   (rd_burst_done),
    .timeout_err     (timeout_err),
    .busy            (busy)
  );

  // Output bit order: {wr_req, rd_req, wr_done, rd_done, timeout_err, busy}
  typedef struct {
    string      nm;
    logic       init;
    logic [9:0] wrf;
    logic [9:0] wrl;
    logic [9:0] rdf;
    logic [9:0] rdl;
    logic       rv;
    logic       wa;
    logic       ra;
    logic [5:0] exp;
  } vec_t;

  vec_t vt[$];
  byte  sb[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {sdram_wr_req, sdram_rd_req, wr_burst_done, rd_burst_done, timeout_err, busy};
  endfunction

  task automatic add(input string nm, input logic init, input int wrf, input int wrl,
                     input int rdf, input int rdl, input logic rv, input logic wa,
                     input logic ra, input logic [5:0] exp);
    vec_t v;
    v.nm = nm; v.init = init; v.wrf = 10'(wrf); v.wrl = 10'(wrl);
    v.rdf = 10'(rdf); v.rdl = 10'(rdl); v.rv = rv; v.wa = wa; v.ra = ra; v.exp = exp;
    vt.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk_ref);
    #1;
  endtask

  initial begin
    int n;
    int bad;
    int ack_cnt;
    int overlap;

    rst_n = 1'b0; sdram_init_done = 1'b0; wrf_use = '0; wr_length = '0;
    rdf_use = '0; rd_length = '0; read_valid = 1'b0; sdram_wr_ack = 1'b0;
    sdram_rd_ack = 1'b0;
    repeat (3) tick();
    chk("reset_outs", int'(outs()), 0);
    @(negedge clk_ref) rst_n = 1'b1;

    //   name          init wrf  wrl  rdf  rdl  rv wa ra  expected
    add("init_low",     0, 1023, 256,   0,   0, 0, 0, 0, 6'b000000);
    add("wrf_short",    1,  255, 256,   0,   0, 0, 0, 0, 6'b000000);
    add("wr_req_rise",  1,  256, 256,   0,   0, 0, 0, 0, 6'b100001);
    add("wr_req_hold",  1,  256, 256,   0,   0, 0, 0, 0, 6'b100001);
    add("wr_ack",       1,  256, 256,   0,   0, 0, 1, 0, 6'b000001);
    add("wr_init_drop", 0,  256, 256,   0,   0, 0, 1, 0, 6'b000001);
    add("wr_done",      0,  256, 256,   0,   0, 0, 0, 0, 6'b001000);
    add("no_req_init0", 0,  256, 256,   0,   0, 0, 0, 0, 6'b000000);
    add("rd_req_rise",  1,    0, 256,   0, 256, 1, 0, 0, 6'b010001);
    add("rd_withdraw",  1,    0, 256,   0, 256, 0, 0, 0, 6'b000000);
    add("rd_req_again", 1,    0, 256,   0, 256, 1, 0, 0, 6'b010001);
    add("rd_ack",       1,    0, 256,   0, 256, 1, 1, 1, 6'b000001);
    add("rd_done",      1,    0, 256,   0, 256, 1, 0, 0, 6'b000100);
    add("rdf_full",     1,    0, 256, 256, 256, 1, 0, 0, 6'b000000);
    add("wrl_zero",     1, 1023,   0, 256, 256, 1, 0, 0, 6'b000000);
    add("rdl_zero",     1, 1023,   0,   0,   0, 1, 0, 0, 6'b000000);
    add("wr_small",     1,    4,   4,   0,   0, 1, 0, 0, 6'b100001);
    add("wr_withdraw",  1,    3,   4,   0,   0, 1, 0, 0, 6'b000000);
    add("wr_small2",    1,    4,   4,   0,   0, 1, 0, 0, 6'b100001);
    add("ack_vs_drop",  1,    0,   4,   0,   0, 1, 1, 0, 6'b000001);
    add("wr_done2",     1,    0,   4,   0,   0, 1, 0, 0, 6'b001000);
    add("wr_req3",      1,    4,   4,   0,   0, 1, 0, 1, 6'b100001);
    add("rd_ack_ignor", 1,    4,   4,   0,   0, 1, 0, 1, 6'b100001);
    add("wr_ack3",      1,    4,   4,   0,   0, 1, 1, 0, 6'b000001);
    add("wr_done3",     1,    0,   4,   0,   0, 1, 0, 0, 6'b001000);
    add("idle_end",     1,    0,   4,   0,   0, 1, 0, 0, 6'b000000);

    foreach (vt[i]) begin
      @(negedge clk_ref);
      sdram_init_done = vt[i].init; wrf_use = vt[i].wrf; wr_length = vt[i].wrl;
      rdf_use = vt[i].rdf; rd_length = vt[i].rdl; read_valid = vt[i].rv;
      sdram_wr_ack = vt[i].wa; sdram_rd_ack = vt[i].ra;
      tick();
      chk(vt[i].nm, int'(outs()), int'(vt[i].exp));
    end

    // Long write burst: ack held 260 cycles.
    @(negedge clk_ref);
    sdram_init_done = 1'b1; read_valid = 1'b0; wr_length = 10'd256; wrf_use = 10'd255;
    sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
    tick();
    chk("t1_no_req_255", int'(sdram_wr_req), 0);
    @(negedge clk_ref) wrf_use = 10'd256;
    tick();
    chk("t1_req_256", int'(sdram_wr_req), 1);
    @(negedge clk_ref) sdram_wr_ack = 1'b1;
    tick();
    chk("t1_req_drop", int'(sdram_wr_req), 0);
    chk("t1_busy", int'(busy), 1);
    bad = 0;
    repeat (259) begin
      tick();
      if (sdram_wr_req || wr_burst_done || !busy) bad++;
    end
    chk("t1_burst_quiet", bad, 0);
    @(negedge clk_ref) begin sdram_wr_ack = 1'b0; wrf_use = 10'd0; end
    tick();
    chk("t1_done_pulse", int'(wr_burst_done), 1);
    chk("t1_idle", int'(busy), 0);
    tick();
    chk("t1_done_once", int'(wr_burst_done), 0);

    // Fairness: four writes, one read, then writes resume.
    sb = '{"W", "W", "W", "W", "R", "W", "W"};
    @(negedge clk_ref);
    wrf_use = 10'd512; wr_length = 10'd256; rdf_use = 10'd0; rd_length = 10'd256;
    read_valid = 1'b1;
    ack_cnt = 0; overlap = 0; n = 0;
    while (sb.size() != 0 && n < 3000) begin
      tick();
      n++;
      if (sdram_wr_req && sdram_rd_req) overlap++;
      if (wr_burst_done) begin
        if (sb.size() != 0) chk("t2_burst_order", int'("W"), int'(sb.pop_front()));
        else chk("t2_extra_wr", 1, 0);
      end
      if (rd_burst_done) begin
        if (sb.size() != 0) chk("t2_burst_order", int'("R"), int'(sb.pop_front()));
        else chk("t2_extra_rd", 1, 0);
      end
      if (sdram_wr_req && !sdram_wr_ack) begin
        sdram_wr_ack = 1'b1; ack_cnt = 8;
      end else if (sdram_rd_req && !sdram_rd_ack) begin
        sdram_rd_ack = 1'b1; ack_cnt = 8;
      end else if (sdram_wr_ack || sdram_rd_ack) begin
        ack_cnt--;
        if (ack_cnt == 0) begin sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0; end
      end
    end
    wrf_use = 10'd0; read_valid = 1'b0; sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
    chk("t2_sb_empty", sb.size(), 0);
    chk("t2_no_overlap", overlap, 0);
    tick();
    chk("t2_idle_after", int'(busy), 0);

    // Read request never acknowledged.
    @(negedge clk_ref);
    read_valid = 1'b1; rdf_use = 10'd0; rd_length = 10'd256; wrf_use = 10'd0;
    tick();
    chk("t3_rd_req", int'(sdram_rd_req), 1);
    n = 0;
    while (sdram_rd_req && n < 1100) begin
      n++;
      tick();
    end
    chk("t3_req_cycles", n, 1023);
    chk("t3_timeout_pulse", int'(timeout_err), 1);
    chk("t3_idle_gap", int'(busy), 0);
    tick();
    chk("t3_rerequest", int'(sdram_rd_req), 1);
    chk("t3_pulse_once", int'(timeout_err), 0);
    @(negedge clk_ref) read_valid = 1'b0;
    tick();
    chk("t3_withdraw", int'(outs()), 0);

    // Asynchronous reset during a write burst.
    @(negedge clk_ref);
    wr_length = 10'd256; wrf_use = 10'd256;
    tick();
    chk("t6_wr_req", int'(sdram_wr_req), 1);
    sdram_wr_ack = 1'b1;
    tick();
    tick();
    chk("t6_in_burst", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1 chk("t6_async_reset", int'(outs()), 0);
    sdram_wr_ack = 1'b0; wr_length = 10'd0; wrf_use = 10'd1023;
    @(negedge clk_ref) rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      tick();
      if (sdram_wr_req || busy) bad++;
    end
    chk("t6_no_req_len0", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case a loop above ever fails to make progress.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, errors %0d", errors);
    $fatal(1);
  end

endmodule
